// File: rtl/io_mailbox_pkg.sv
// io_mailbox_pkg: shared FSM states, opcodes and status bit positions
package io_mailbox_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2} state_t;
  localparam logic [3:0] OP_CLR_EVT = 4'd0;
  localparam int STAT_ACK  = 31;
  localparam int STAT_BUSY = 30;
  localparam int STAT_JUMP = 1;
  localparam int STAT_EVT  = 0;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer plus counter debounce for a raw pushbutton
//   clock, reset : shared clock, async active-high reset
//   raw          : asynchronous button input
//   level        : debounced stable level
//   rise         : one-clock pulse when level goes 0->1
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/io_mailbox.sv
// io_mailbox: toggle-handshake command mailbox, debounced jump button and frame counter
//   clock, reset     : shared clock, async active-high reset
//   r16, r17         : processor command (bit 31 toggle, 3:0 opcode) and payload
//   r20, r22         : status (ack, busy, jump level, jump event) and frame count
//   btn_jump         : raw pushbutton
//   cmd_valid/op/data, cmd_ready : peripheral command handshake
//   frame_tick       : one-clock pulse per frame
module io_mailbox
  import io_mailbox_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAME_CYCLES    = 416667
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] r16,
  input  logic [31:0] r17,
  output logic [31:0] r20,
  output logic [31:0] r22,
  input  logic        btn_jump,
  output logic        cmd_valid,
  output logic [3:0]  cmd_op,
  output logic [31:0] cmd_data,
  input  logic        cmd_ready,
  output logic        frame_tick
);
  localparam int FW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  state_t state, state_n;
  logic ack, busy, evt, level, rise, req, clr, term, unused_bits;
  logic [FW-1:0] fcnt;
  assign unused_bits = ^r16[30:4];
  assign req  = r16[31] != ack;
  assign clr  = state == ACK && cmd_op == OP_CLR_EVT;
  assign term = fcnt == FW'(FRAME_CYCLES - 1);
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock(clock),
    .reset(reset),
    .raw(btn_jump),
    .level(level),
    .rise(rise)
  );
  // cmd_valid is always high in ISSUE, so cmd_ready alone completes the handshake
  always_comb
    state_n = state == IDLE  ? (req ? (r16[3:0] != OP_CLR_EVT ? ISSUE : ACK) : IDLE) :
              state == ISSUE ? (cmd_ready ? ACK : ISSUE) : IDLE;
  always_comb begin
    r20 = '0;
    r20[STAT_ACK]  = ack;
    r20[STAT_BUSY] = busy;
    r20[STAT_JUMP] = level;
    r20[STAT_EVT]  = evt;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      ack       <= 1'b0;
      busy      <= 1'b0;
      evt       <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_data  <= '0;
    end else begin
      state     <= state_n;
      busy      <= state_n != IDLE;
      cmd_valid <= state_n == ISSUE;
      if (state == IDLE && req) begin
        cmd_op   <= r16[3:0];
        cmd_data <= r17;
      end
      if (state == ACK) ack <= ~ack;
      // a debounced rise in the same cycle as a clear keeps the event set
      evt <= rise | (evt & ~clr);
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fcnt       <= '0;
      frame_tick <= 1'b0;
      r22        <= '0;
    end else begin
      fcnt       <= term ? '0 : fcnt + 1'b1;
      frame_tick <= term;
      r22        <= r22 + 32'(term);
    end
endmodule

// File: tb/tb_io_mailbox.sv
// tb_io_mailbox: directed self-checking bench for io_mailbox
module tb_io_mailbox;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] r16, r17, r20, r22, cmd_data;
  logic        btn_jump, cmd_valid, cmd_ready, frame_tick;
  logic [3:0]  cmd_op;
  int checks = 0;
  int errors = 0;
  io_mailbox #(.DEBOUNCE_CYCLES(4), .FRAME_CYCLES(10)) dut (
    .clock(clock),
    .reset(reset),
    .r16(r16),
    .r17(r17),
    .r20(r20),
    .r22(r22),
    .btn_jump(btn_jump),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .frame_tick(frame_tick)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    r16 = '0;
    r17 = '0;
    btn_jump = 1'b0;
    cmd_ready = 1'b0;
    step(2);
    check("rst_r20", r20, 32'h0);
    check("rst_r22", r22, 32'h0);
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_data", cmd_data, 32'h0);
    check("rst_tick", frame_tick, 0);
    reset = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      check("frame_tick", frame_tick, i % 10 == 0);
      if (i % 10 == 0) check("frame_r22", r22, 32'(i / 10));
    end
    force dut.r22 = 32'hFFFF_FFFF;
    step(5);
    release dut.r22;
    check("r22_forced", r22, 32'hFFFF_FFFF);
    step(4);
    check("wrap_pre_tick", frame_tick, 0);
    step(1);
    check("wrap_tick", frame_tick, 1);
    check("wrap_r22", r22, 32'h0);
    r16 = 32'h8000_0005;
    r17 = 32'hDEAD_BEEF;
    step(1);
    check("iss_valid", cmd_valid, 1);
    check("iss_op", cmd_op, 5);
    check("iss_data", cmd_data, 32'hDEAD_BEEF);
    check("iss_busy", r20, 32'h4000_0000);
    step(1);
    check("iss_hold_valid", cmd_valid, 1);
    r16 = 32'h8000_0007;
    r17 = 32'h1234_5678;
    step(1);
    check("iss_hold_valid2", cmd_valid, 1);
    check("iss_hold_op", cmd_op, 5);
    check("iss_hold_data", cmd_data, 32'hDEAD_BEEF);
    cmd_ready = 1'b1;
    step(1);
    check("hs_valid_low", cmd_valid, 0);
    check("hs_ack_state", r20, 32'h4000_0000);
    cmd_ready = 1'b0;
    step(1);
    check("ack_flip", r20, 32'h8000_0000);
    step(1);
    check("no_reissue", cmd_valid, 0);
    check("idle_r20", r20, 32'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      btn_jump = 1'b1;
      for (int j = 0; j < 2; j++) begin step(1); check("bounce_hi", r20[1], 0); end
      btn_jump = 1'b0;
      for (int j = 0; j < 2; j++) begin step(1); check("bounce_lo", r20[1], 0); end
    end
    btn_jump = 1'b1;
    for (int j = 0; j < 5; j++) begin step(1); check("hold_wait", r20[1], 0); end
    step(1);
    check("hold_level", r20[1], 1);
    check("hold_evt_pre", r20[0], 0);
    step(1);
    check("hold_evt", r20[0], 1);
    step(1);
    r16 = 32'h0;
    step(1);
    check("clr_valid1", cmd_valid, 0);
    check("clr_busy", r20[30], 1);
    step(1);
    check("clr_valid2", cmd_valid, 0);
    check("clr_r20", r20, 32'h0000_0002);
    step(1);
    check("clr_valid3", cmd_valid, 0);
    btn_jump = 1'b0;
    step(8);
    check("release_r20", r20, 32'h0);
    btn_jump = 1'b1;
    step(5);
    check("race_pre_level", r20[1], 0);
    r16 = 32'h8000_0000;
    step(1);
    check("race_ack_state", r20, 32'h4000_0002);
    step(1);
    check("race_set_wins", r20, 32'h8000_0003);
    btn_jump = 1'b0;
    r16 = 32'h0000_0003;
    r17 = 32'hCAFE_F00D;
    step(1);
    check("mid_valid", cmd_valid, 1);
    check("mid_op", cmd_op, 3);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_op", cmd_op, 0);
    check("mid_rst_r20", r20, 32'h0);
    check("mid_rst_r22", r22, 32'h0);
    r16 = 32'h8000_0003;
    step(1);
    reset = 1'b0;
    step(1);
    check("reissue_valid", cmd_valid, 1);
    check("reissue_op", cmd_op, 3);
    check("reissue_data", cmd_data, 32'hCAFE_F00D);
    check("reissue_busy", r20, 32'h4000_0000);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    step(1);
    check("reissue_ack", r20, 32'h8000_0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
